// File: rtl/manchester_pkg.sv
// Shared types and line-coding helper for the serial Manchester transmitter.
// Holds the frame state enum, the per-frame mode constants and the half-bit level function.
package manchester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic MODE_IEEE   = 1'b0;
    localparam logic MODE_THOMAS = 1'b1;

    // IEEE 802.3: 1 -> low,high ; Thomas: 1 -> high,low (the complement).
    function automatic logic manch_half(input logic b, input logic mode, input logic second_half);
        return (mode == MODE_THOMAS) ? (b ^ second_half) : ~(b ^ second_half);
    endfunction

endpackage

// File: rtl/manchester_bit_timer.sv
// Half-bit timer: counts HALF_BIT_CYCLES enabled cycles per half-bit and tracks bit phase.
// Latency: half_tick_o is combinational on the last cycle of a half; phase_o flips after it.
module manchester_bit_timer #(
    parameter int HALF_BIT_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic half_tick_o,
    output logic phase_o
);

    localparam int CW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    assign half_tick_o = en_i & (cnt_q == LAST);
    assign phase_o     = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/manchester_serial_tx.sv
// Serial Manchester transmitter: preamble, coded payload, optional parity (MANCH_PARITY_EN), idle-low stop.
// Latency: first line level one cycle after accept; s_ready only in IDLE with ena=1, ena=0 freezes everything.
module manchester_serial_tx
    import manchester_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int HALF_BIT_CYCLES = 4,
    parameter int PREAMBLE_BITS   = 8,
    parameter int MSB_FIRST       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              tx_out,
    output logic              tx_oe,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
    localparam int BW      = $clog2(CNT_MAX + 1);
    localparam logic [BW-1:0] PRE_LAST  = BW'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, shifted;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              mode_q, mode_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              cur_bit, accept, busy_int, half_tick, phase;
`ifdef MANCH_PARITY_EN
    logic              parity_q, parity_d;
`endif

    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    assign busy_int = (state_q != IDLE);
    assign s_ready  = (state_q == IDLE) & ena;
    assign accept   = s_valid & s_ready;
    assign shifted  = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

    assign tx_out = tx_q;
    assign tx_oe  = busy_int;
    assign busy   = busy_int;
    assign done   = done_q;

    manchester_bit_timer #(.HALF_BIT_CYCLES(HALF_BIT_CYCLES)) u_timer (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (ena & busy_int),
        .clr_i       (accept),
        .half_tick_o (half_tick),
        .phase_o     (phase)
    );

    always_comb begin
        cur_bit = 1'b0;
        case (state_q)
            PREAMBLE: cur_bit = ~bit_cnt_q[0];
            DATA:     cur_bit = head_bit(shreg_q);
`ifdef MANCH_PARITY_EN
            PARITY:   cur_bit = parity_q;
`endif
            default:  cur_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        mode_d    = mode_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
`ifdef MANCH_PARITY_EN
        parity_d  = parity_q;
`endif
        if (accept) begin
            shreg_d   = s_data;
            mode_d    = mode;
            bit_cnt_d = '0;
`ifdef MANCH_PARITY_EN
            parity_d  = ^s_data;
`endif
            if (PREAMBLE_BITS > 0) begin
                state_d = PREAMBLE;
                tx_d    = manch_half(1'b1, mode, 1'b0);
            end else begin
                state_d = DATA;
                tx_d    = manch_half(head_bit(s_data), mode, 1'b0);
            end
        end else if (busy_int && half_tick) begin
            if (!phase) begin
                tx_d = (state_q == STOP) ? 1'b0 : manch_half(cur_bit, mode_q, 1'b1);
            end else begin
                // Bit boundary: advance and present the first half of whatever comes next.
                case (state_q)
                    PREAMBLE: begin
                        if (bit_cnt_q == PRE_LAST) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                            tx_d      = manch_half(head_bit(shreg_q), mode_q, 1'b0);
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                            tx_d      = manch_half(bit_cnt_q[0], mode_q, 1'b0);
                        end
                    end
                    DATA: begin
                        shreg_d = shifted;
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
`ifdef MANCH_PARITY_EN
                            state_d   = PARITY;
                            tx_d      = manch_half(parity_q, mode_q, 1'b0);
`else
                            state_d   = STOP;
                            tx_d      = 1'b0;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                            tx_d      = manch_half(head_bit(shifted), mode_q, 1'b0);
                        end
                    end
`ifdef MANCH_PARITY_EN
                    PARITY: begin
                        state_d = STOP;
                        tx_d    = 1'b0;
                    end
`endif
                    STOP: begin
                        state_d = IDLE;
                        tx_d    = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                        tx_d    = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            mode_q    <= MODE_IEEE;
            tx_q      <= 1'b0;
            done_q    <= 1'b0;
`ifdef MANCH_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (ena) begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            mode_q    <= mode_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
`ifdef MANCH_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule
